pwm_multi_timer: RTL and testbench

Multi-channel, double-buffered PWM timer for the GPMC-attached FPGA. The DSP stages per-channel switch-on/switch-off counts through the GPMC register file and flags them valid. The block latches them at a fixed lead before the period boundary and applies them at the boundary. It also generates the per-period DSP interrupt and a stale-data flag, and drives the PWM pins.

---
 rtl/pwm_multi_timer.sv | 165 ++++++++++++++++
 tb/tb_pwm_multi_timer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi_timer.sv
// ---------------------------------------------------------------------------
// pwm_multi_timer
//   Multi-channel double-buffered PWM timer. Switch-on/off compares are staged
//   per channel, captured DVALID_LEAD clocks before the period end when the
//   staged set was flagged valid (zeroed and flagged stale otherwise), and
//   applied at the period wrap. Generates a per-period irq pulse.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   en          run enable; low holds counter at 0 and outputs inactive
//   period      terminal count (period is period+1 clocks, clamped low)
//   polarity    per-channel output inversion (1 = active low)
//   wr_en       staging write strobe
//   wr_ch       staging channel index
//   wr_on       staged switch-on count
//   wr_off      staged switch-off count
//   data_valid  one-cycle pulse marking the staged set complete
//   pwm_out     registered PWM outputs
//   irq         registered period interrupt
//   stale       current period runs on zeroed compares
//   counter     current period count
// ---------------------------------------------------------------------------
module pwm_multi_timer #(
  parameter int CHANNELS    = 4,
  parameter int CNT_WIDTH   = 16,
  parameter int IRQ_LEN     = 100,
  parameter int DVALID_LEAD = 200,
  parameter int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [CNT_WIDTH-1:0] period,
  input  logic [CHANNELS-1:0]  polarity,
  input  logic                 wr_en,
  input  logic [CH_W-1:0]      wr_ch,
  input  logic [CNT_WIDTH-1:0] wr_on,
  input  logic [CNT_WIDTH-1:0] wr_off,
  input  logic                 data_valid,
  output logic [CHANNELS-1:0]  pwm_out,
  output logic                 irq,
  output logic                 stale,
  output logic [CNT_WIDTH-1:0] counter
);

  // Smallest period that still leaves room for the capture point.
  localparam logic [CNT_WIDTH-1:0] P_MIN     = CNT_WIDTH'(DVALID_LEAD + 2);
  localparam logic [CNT_WIDTH-1:0] LEAD      = CNT_WIDTH'(DVALID_LEAD);
  localparam logic [32:0]          IRQ_LEN_U = 33'(IRQ_LEN);

  logic [CNT_WIDTH-1:0] r_counter;
  logic [CNT_WIDTH-1:0] r_period_cur;
  logic [CNT_WIDTH-1:0] r_stage_on  [CHANNELS];
  logic [CNT_WIDTH-1:0] r_stage_off [CHANNELS];
  logic [CNT_WIDTH-1:0] r_next_on   [CHANNELS];
  logic [CNT_WIDTH-1:0] r_next_off  [CHANNELS];
  logic [CNT_WIDTH-1:0] r_curr_on   [CHANNELS];
  logic [CNT_WIDTH-1:0] r_curr_off  [CHANNELS];
  logic                 r_valid;
  logic                 r_stale_next;
  logic                 r_stale;
  logic [CHANNELS-1:0]  r_pwm;
  logic                 r_irq;

  logic [CNT_WIDTH-1:0] w_p_eff;
  logic                 w_wrap;
  logic                 w_capture;
  logic                 w_valid_now;
  logic                 w_irq_window;
  logic [CHANNELS-1:0]  w_active;

  // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    w_p_eff      = (period > P_MIN) ? period : P_MIN;
    w_wrap       = en && (r_counter == r_period_cur);
    w_capture    = en && (r_counter == (r_period_cur - LEAD));
    // A data_valid pulse in the capture cycle itself still counts.
    w_valid_now  = r_valid | data_valid;
    w_irq_window = ({{(33 - CNT_WIDTH){1'b0}}, r_counter} < IRQ_LEN_U);
    w_active     = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_active[i] = (r_counter >= r_curr_on[i]) && (r_counter < r_curr_off[i]);
    end
  end

  // Period counter; period_cur only reloads while idle or at the wrap.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_counter    <= '0;
      r_period_cur <= '0;
    end else if (!en || w_wrap) begin
      r_counter    <= '0;
      r_period_cur <= w_p_eff;
    end else begin
      r_counter    <= r_counter + CNT_WIDTH'(1);
    end
  end

  // Staging registers and valid flag; both keep working while en is low.
  // NOTE: the compare arrays are reset explicitly because their reset value (0) is observable behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_stage_on[i]  <= '0;
        r_stage_off[i] <= '0;
      end
      r_valid <= 1'b0;
    end else begin
      if (wr_en && (int'(wr_ch) < CHANNELS)) begin
        r_stage_on[wr_ch]  <= wr_on;
        r_stage_off[wr_ch] <= wr_off;
      end
      if (data_valid)           r_valid <= 1'b1;
      else if (r_counter == '0) r_valid <= 1'b0;
    end
  end

  // Double buffer: stage -> next at capture, next -> curr at the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_next_on[i]  <= '0;
        r_next_off[i] <= '0;
        r_curr_on[i]  <= '0;
        r_curr_off[i] <= '0;
      end
      r_stale_next <= 1'b0;
      r_stale      <= 1'b0;
    end else begin
      if (w_capture) begin
        for (int i = 0; i < CHANNELS; i++) begin
          r_next_on[i]  <= w_valid_now ? r_stage_on[i]  : '0;
          r_next_off[i] <= w_valid_now ? r_stage_off[i] : '0;
        end
        r_stale_next <= !w_valid_now;
      end
      if (w_wrap) begin
        for (int i = 0; i < CHANNELS; i++) begin
          r_curr_on[i]  <= r_next_on[i];
          r_curr_off[i] <= r_next_off[i];
        end
        r_stale <= r_stale_next;
      end
    end
  end

  // Outputs registered from the counter: one clock behind it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm <= '0;
      r_irq <= 1'b0;
    end else begin
      r_pwm <= en ? (w_active ^ polarity) : polarity;
      r_irq <= en && w_irq_window;
    end
  end

  assign pwm_out = r_pwm;
  assign irq     = r_irq;
  assign stale   = r_stale;
  assign counter = r_counter;

endmodule

// File: tb/tb_pwm_multi_timer.sv
// ---------------------------------------------------------------------------
// tb_pwm_multi_timer
//   Directed bench for pwm_multi_timer with CHANNELS=2, CNT_WIDTH=8,
//   IRQ_LEN=3, DVALID_LEAD=4, period=19 (20-clock periods, capture at 15).
//   Inputs are driven and outputs sampled on the falling edge. A period trace
//   bit k holds the output produced for counter value k.
// ---------------------------------------------------------------------------
module tb_pwm_multi_timer;

  localparam int CHANNELS    = 2;
  localparam int CNT_WIDTH   = 8;
  localparam int IRQ_LEN     = 3;
  localparam int DVALID_LEAD = 4;
  localparam int CH_W        = 1;

  logic                 clk;
  logic                 rst_n;
  logic                 en;
  logic [CNT_WIDTH-1:0] period;
  logic [CHANNELS-1:0]  polarity;
  logic                 wr_en;
  logic [CH_W-1:0]      wr_ch;
  logic [CNT_WIDTH-1:0] wr_on;
  logic [CNT_WIDTH-1:0] wr_off;
  logic                 data_valid;
  logic [CHANNELS-1:0]  pwm_out;
  logic                 irq;
  logic                 stale;
  logic [CNT_WIDTH-1:0] counter;

  int n_pass   = 0;
  int n_checks = 0;

  logic [19:0] tr_ch0;
  logic [19:0] tr_ch1;
  logic [19:0] tr_irq;
  logic        tr_stale;

  pwm_multi_timer #(
    .CHANNELS   (CHANNELS),
    .CNT_WIDTH  (CNT_WIDTH),
    .IRQ_LEN    (IRQ_LEN),
    .DVALID_LEAD(DVALID_LEAD),
    .CH_W       (CH_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .period    (period),
    .polarity  (polarity),
    .wr_en     (wr_en),
    .wr_ch     (wr_ch),
    .wr_on     (wr_on),
    .wr_off    (wr_off),
    .data_valid(data_valid),
    .pwm_out   (pwm_out),
    .irq       (irq),
    .stale     (stale),
    .counter   (counter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one 20-clock period starting at a falling edge with counter==0,
  // optionally pulsing data_valid / writing stage at given counter values.
  task automatic run_period(input int dv_at, input int wr_at, input logic wr_ch_v,
                            input logic [7:0] on_v, input logic [7:0] off_v);
    n_checks++;
    if (counter !== 8'd0) $display("FAIL period_align: counter=%0d expected 0", counter);
    else n_pass++;
    tr_stale = stale;
    for (int k = 0; k < 20; k++) begin
      data_valid = (k == dv_at);
      wr_en      = (k == wr_at);
      wr_ch      = wr_ch_v;
      wr_on      = on_v;
      wr_off     = off_v;
      @(negedge clk);
      tr_ch0[k] = pwm_out[0];
      tr_ch1[k] = pwm_out[1];
      tr_irq[k] = irq;
    end
    data_valid = 1'b0;
    wr_en      = 1'b0;
  endtask

  task automatic stage_write(input logic ch, input logic [7:0] on_v, input logic [7:0] off_v);
    wr_en  = 1'b1;
    wr_ch  = ch;
    wr_on  = on_v;
    wr_off = off_v;
    @(negedge clk);
    wr_en  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; period = 8'd19; polarity = 2'b01;
    wr_en = 1'b0; wr_ch = '0; wr_on = '0; wr_off = '0; data_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (counter !== 8'd0) $display("FAIL reset_counter: got %0d expected 0", counter); else n_pass++;
    n_checks++; if (pwm_out !== 2'b00) $display("FAIL reset_pwm: got %b expected 00", pwm_out); else n_pass++;
    n_checks++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b expected 0", irq); else n_pass++;
    n_checks++; if (stale !== 1'b0) $display("FAIL reset_stale: got %b expected 0", stale); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (pwm_out !== 2'b01) $display("FAIL idle_polarity: got %b expected 01", pwm_out); else n_pass++;
    polarity = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_basic();
    stage_write(1'b0, 8'd5, 8'd10);
    stage_write(1'b1, 8'd0, 8'd20);
    en = 1'b1;
    run_period(2, -1, 1'b0, 8'd0, 8'd0);   // A: valid at 2, captured for B
    run_period(-1, -1, 1'b0, 8'd0, 8'd0);  // B: no valid for C
    n_checks++; if (tr_ch0 !== 20'h003E0) $display("FAIL basic_ch0: got %h expected 003e0", tr_ch0); else n_pass++;
    n_checks++; if (tr_ch1 !== 20'hFFFFF) $display("FAIL basic_ch1: got %h expected fffff", tr_ch1); else n_pass++;
    n_checks++; if (tr_irq !== 20'h00007) $display("FAIL basic_irq: got %h expected 00007", tr_irq); else n_pass++;
    n_checks++; if (tr_stale !== 1'b0) $display("FAIL basic_stale: got %b expected 0", tr_stale); else n_pass++;
  endtask

  task automatic test_missing_valid();
    run_period(2, -1, 1'b0, 8'd0, 8'd0);   // C: zeroed, valid again for D
    n_checks++; if (tr_ch0 !== 20'h00000) $display("FAIL missing_ch0: got %h expected 00000", tr_ch0); else n_pass++;
    n_checks++; if (tr_ch1 !== 20'h00000) $display("FAIL missing_ch1: got %h expected 00000", tr_ch1); else n_pass++;
    n_checks++; if (tr_stale !== 1'b1) $display("FAIL missing_stale: got %b expected 1", tr_stale); else n_pass++;
    run_period(15, -1, 1'b0, 8'd0, 8'd0);  // D: recovered; valid exactly at capture
    n_checks++; if (tr_ch0 !== 20'h003E0) $display("FAIL recover_ch0: got %h expected 003e0", tr_ch0); else n_pass++;
    n_checks++; if (tr_stale !== 1'b0) $display("FAIL recover_stale: got %b expected 0", tr_stale); else n_pass++;
  endtask

  task automatic test_late_valid();
    run_period(16, -1, 1'b0, 8'd0, 8'd0);  // E: captured at 15; valid at 16 too late
    n_checks++; if (tr_stale !== 1'b0) $display("FAIL at_capture_stale: got %b expected 0", tr_stale); else n_pass++;
    n_checks++; if (tr_ch0 !== 20'h003E0) $display("FAIL at_capture_ch0: got %h expected 003e0", tr_ch0); else n_pass++;
    run_period(-1, -1, 1'b0, 8'd0, 8'd0);  // F
    n_checks++; if (tr_stale !== 1'b1) $display("FAIL late_stale: got %b expected 1", tr_stale); else n_pass++;
    n_checks++; if (tr_ch0 !== 20'h00000) $display("FAIL late_ch0: got %h expected 00000", tr_ch0); else n_pass++;
    run_period(2, 15, 1'b0, 8'd7, 8'd10);  // G: valid at 2, write collides with capture
    n_checks++; if (tr_stale !== 1'b1) $display("FAIL late_cleared_stale: got %b expected 1", tr_stale); else n_pass++;
  endtask

  task automatic test_write_collision();
    run_period(2, -1, 1'b0, 8'd0, 8'd0);   // H: old on=5
    n_checks++; if (tr_ch0 !== 20'h003E0) $display("FAIL collision_old_ch0: got %h expected 003e0", tr_ch0); else n_pass++;
    run_period(6, 5, 1'b0, 8'd10, 8'd10);  // I: new on=7
    n_checks++; if (tr_ch0 !== 20'h00380) $display("FAIL collision_new_ch0: got %h expected 00380", tr_ch0); else n_pass++;
  endtask

  task automatic test_edge_compares();
    run_period(6, 5, 1'b0, 8'd18, 8'd255); // J: on==off
    n_checks++; if (tr_ch0 !== 20'h00000) $display("FAIL on_eq_off_ch0: got %h expected 00000", tr_ch0); else n_pass++;
    n_checks++; if (tr_ch1 !== 20'hFFFFF) $display("FAIL on_eq_off_ch1: got %h expected fffff", tr_ch1); else n_pass++;
    run_period(6, -1, 1'b0, 8'd0, 8'd0);   // K: off beyond period end
    n_checks++; if (tr_ch0 !== 20'hC0000) $display("FAIL off_past_end_ch0: got %h expected c0000", tr_ch0); else n_pass++;
    polarity = 2'b11;
    run_period(-1, -1, 1'b0, 8'd0, 8'd0);  // L: inverted outputs
    n_checks++; if (tr_ch0 !== 20'h3FFFF) $display("FAIL polarity_ch0: got %h expected 3ffff", tr_ch0); else n_pass++;
    n_checks++; if (tr_ch1 !== 20'h00000) $display("FAIL polarity_ch1: got %h expected 00000", tr_ch1); else n_pass++;
    en = 1'b0;
    @(negedge clk);
    n_checks++; if (pwm_out !== 2'b11) $display("FAIL disabled_pwm: got %b expected 11", pwm_out); else n_pass++;
    n_checks++; if (counter !== 8'd0) $display("FAIL disabled_counter: got %0d expected 0", counter); else n_pass++;
    n_checks++; if (irq !== 1'b0) $display("FAIL disabled_irq: got %b expected 0", irq); else n_pass++;
  endtask

  task automatic test_period_and_reset();
    int len;
    en = 1'b1;
    len = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (i == 5) period = 8'd2;
      if (counter == 8'd0) begin len = i; break; end
    end
    n_checks++; if (len != 20) $display("FAIL period_change_ignored: got length %0d expected 20", len); else n_pass++;
    len = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (i == 3) period = 8'd19;
      if (counter == 8'd0) begin len = i; break; end
    end
    n_checks++; if (len != 7) $display("FAIL period_clamped: got length %0d expected 7", len); else n_pass++;
    for (int i = 0; i < 100; i++) begin
      if (counter == 8'd9) break;
      @(negedge clk);
    end
    n_checks++; if (counter !== 8'd9) $display("FAIL reach_count9: got %0d expected 9", counter); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (counter !== 8'd0) $display("FAIL async_reset_counter: got %0d expected 0", counter); else n_pass++;
    n_checks++; if (pwm_out !== 2'b00) $display("FAIL async_reset_pwm: got %b expected 00", pwm_out); else n_pass++;
    n_checks++; if (irq !== 1'b0) $display("FAIL async_reset_irq: got %b expected 0", irq); else n_pass++;
    n_checks++; if (stale !== 1'b0) $display("FAIL async_reset_stale: got %b expected 0", stale); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_missing_valid();
    test_late_valid();
    test_write_collision();
    test_edge_compares();
    test_period_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
